// File: rtl/attn_pkg.sv
// Shared types and constants for the attention block family.
// Holds the pooling FSM state type, default geometry and the int8 clamp.
package attn_pkg;

   localparam int MATRIX_SIZE = 16;
   localparam int DATA_WIDTH  = 8;
   localparam int ACC_W       = DATA_WIDTH + $clog2(MATRIX_SIZE) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } pool_state_t;

   function automatic logic signed [7:0] sat_int8(input logic signed [31:0] v);
      if (v > 32'sd127) return 8'sh7f;
      if (v < -32'sd128) return 8'sh80;
      return v[7:0];
   endfunction

endpackage

// File: rtl/pool_requant.sv
// One lane of the pooled-vector requantizer: round half up, arithmetic
// shift, then clamp to the signed output range. Purely combinational.
module pool_requant #(
   parameter int DATA_WIDTH = attn_pkg::DATA_WIDTH,
   parameter int ACC_W      = attn_pkg::ACC_W,
   parameter int SHIFT      = 4
) (
   input  logic signed [ACC_W-1:0]      acc,
   output logic signed [DATA_WIDTH-1:0] q
);
   import attn_pkg::*;

   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);

   logic signed [ACC_W-1:0] rounded;
   logic signed [ACC_W-1:0] shifted;

   // The accumulator carries one spare bit, so adding HALF cannot wrap.
   assign rounded = acc + HALF;
   assign shifted = rounded >>> SHIFT;

   if (DATA_WIDTH == 8) begin : g_int8
      assign q = sat_int8(32'(shifted));
   end else begin : g_generic
      localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
      assign q = (shifted > MAXV) ? MAXV[DATA_WIDTH-1:0] :
                 (shifted < MINV) ? MINV[DATA_WIDTH-1:0] :
                 shifted[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/attention_pool.sv
// Mean-pools a snapshot of the attention output over its rows, one row per
// cycle, and hands the requantized feature vector to the classifier head.
module attention_pool #(
   parameter int MATRIX_SIZE = attn_pkg::MATRIX_SIZE,
   parameter int DATA_WIDTH  = attn_pkg::DATA_WIDTH,
   parameter int SHIFT       = 4
) (
   input  logic                                                         clk,
   input  logic                                                         rst,
   input  logic                                                         start,
   input  logic signed [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][DATA_WIDTH-1:0] mat_in,
   output logic                                                         busy,
   output logic signed [0:MATRIX_SIZE-1][DATA_WIDTH-1:0]                vec_out,
   output logic                                                         vec_valid,
   input  logic                                                         vec_ready,
   output attn_pkg::pool_state_t                                        state_dbg
);
   import attn_pkg::*;

   localparam int ACC_BITS = DATA_WIDTH + $clog2(MATRIX_SIZE) + 1;
   localparam int ROW_W    = $clog2(MATRIX_SIZE);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_SIZE - 1);

   pool_state_t state_q;
   pool_state_t state_d;
   logic        load;

   logic signed [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][DATA_WIDTH-1:0] snap;
   logic signed [ACC_BITS-1:0]   acc [MATRIX_SIZE];
   logic signed [DATA_WIDTH-1:0] q   [MATRIX_SIZE];
   logic [ROW_W-1:0]             row;

   // Handshake: a vector transfers on any rising edge where vec_valid and
   // vec_ready are both high; vec_out is frozen from valid until that edge,
   // and vec_ready has no effect while vec_valid is low.
   assign vec_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (row == ROW_LAST) state_d = ROUND;
         end
         ROUND: state_d = OUT;
         OUT: begin
            // An accept and a new start on the same edge chain straight on.
            if (vec_ready) begin
               if (start) begin
                  load    = 1'b1;
                  state_d = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The producer may drop out_matrix right after done, so capture it whole.
   always_ff @(posedge clk) begin
      if (load) snap <= mat_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row     <= '0;
         vec_out <= '0;
         for (int c = 0; c < MATRIX_SIZE; c++) acc[c] <= '0;
      end else begin
         if (load) begin
            row <= '0;
            for (int c = 0; c < MATRIX_SIZE; c++) acc[c] <= '0;
         end else if (state_q == ACCUM) begin
            row <= row + 1'b1;
            for (int c = 0; c < MATRIX_SIZE; c++)
               acc[c] <= acc[c] + ACC_BITS'($signed(snap[row][c]));
         end
         if (state_q == ROUND) begin
            for (int c = 0; c < MATRIX_SIZE; c++) vec_out[c] <= q[c];
         end
      end
   end

   for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_rq
      pool_requant #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_W      (ACC_BITS),
         .SHIFT      (SHIFT)
      ) u_rq (
         .acc (acc[c]),
         .q   (q[c])
      );
   end

endmodule
